// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: issues word-aligned fetches over a valid/ready channel and
// buffers in-order responses in a prefetch queue for decode. Optional counters: FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_starve,
  output logic [31:0] perf_redirects
`endif
);

  localparam int          PW  = $clog2(QDEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [PW-1:0] head_ptr, fill_ptr, tail_ptr;
  logic [CW-1:0] alloc_cnt;   // slots allocated, filled or not
  logic [CW-1:0] pend_cnt;    // allocated slots still waiting for their response
  logic [CW-1:0] drop_cnt;    // in-flight responses that belong to a flushed stream

  logic [31:0]       slot_pc    [QDEPTH];
  logic [31:0]       slot_instr [QDEPTH];
  logic [QDEPTH-1:0] slot_filled;

  logic          accept, pop, rsp_drop, rsp_fill, rsp_counted;
  logic [CW:0]   used_cnt;
  logic [CW-1:0] outstanding, flush_drop;
  logic [31:0]   redirect_target;

  assign used_cnt        = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign imem_req_valid  = !reset && (used_cnt < (CW+1)'(QDEPTH));
  assign imem_req_addr   = fetch_pc;
  assign accept          = imem_req_valid && imem_req_ready;

  assign id_valid        = (alloc_cnt != '0) && slot_filled[head_ptr];
  assign id_pc           = slot_pc[head_ptr];
  assign id_instr        = slot_instr[head_ptr];
  assign pop             = id_valid && id_ready;

  // Responses are in order, so the stale ones always precede the live ones.
  assign outstanding     = drop_cnt + pend_cnt;
  assign rsp_counted     = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop        = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill        = imem_rsp_valid && (drop_cnt == '0) && (pend_cnt != '0);
  assign flush_drop      = outstanding + CW'(accept) - CW'(rsp_counted);
  assign redirect_target = redirect_pc & ~32'h3;

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the combinational helpers above carry all same-cycle dependencies.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      head_ptr    <= '0;
      fill_ptr    <= '0;
      tail_ptr    <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      drop_cnt    <= flush_drop;
      slot_filled <= '0;
      // NOTE: the small slot arrays are reset so id_pc/id_instr come up as 0/NOP.
      for (int i = 0; i < QDEPTH; i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= NOP;
      end
    end else if (redirect) begin
      fetch_pc  <= redirect_target;
      head_ptr  <= '0;
      fill_ptr  <= '0;
      tail_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= flush_drop;
    end else begin
      if (accept) begin
        fetch_pc              <= fetch_pc + 32'd4;
        slot_pc[tail_ptr]     <= fetch_pc;
        slot_filled[tail_ptr] <= 1'b0;
        tail_ptr              <= tail_ptr + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (rsp_fill) begin
        slot_instr[fill_ptr]  <= imem_rsp_data;
        slot_filled[fill_ptr] <= 1'b1;
        fill_ptr              <= fill_ptr + PW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(accept) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(accept) - CW'(rsp_fill);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_starve    <= '0;
      perf_redirects <= '0;
    end else begin
      if (!id_valid) perf_starve    <= perf_starve + 32'd1;
      if (redirect)  perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
